// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
//   arb_state_t : arbiter FSM states
//   requester_t : identity of a requester (fetch or data), used for round-robin
package mem_arb_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 16;
    localparam int unsigned DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data requester. The winning request is latched and held on the memory
// port until mem_resp, and the response is routed back to the winner. Ties
// alternate round-robin.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   imem_read/imem_address     fetch request (read only)
//   imem_rdata/imem_resp       fetch response
//   dmem_read/dmem_write       data request strobes
//   dmem_byte_enable/address/wdata  data request payload
//   dmem_rdata/dmem_resp       data response
//   mem_read/mem_write         memory strobes
//   mem_byte_enable/address/wdata   memory request payload
//   mem_rdata/mem_resp         memory response
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  imem_read,
    input  logic [ADDR_WIDTH-1:0] imem_address,
    output logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  imem_resp,

    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic [BE_WIDTH-1:0]   dmem_byte_enable,
    input  logic [ADDR_WIDTH-1:0] dmem_address,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BE_WIDTH-1:0]   mem_byte_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t            state_q,      state_d;
    requester_t            last_grant_q, last_grant_d;

    logic                  req_read_q,   req_read_d;
    logic                  req_write_q,  req_write_d;
    logic [ADDR_WIDTH-1:0] req_addr_q,   req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q,  req_wdata_d;
    logic [BE_WIDTH-1:0]   req_be_q,     req_be_d;

    logic                  i_req;
    logic                  d_req;
    logic                  load;
    requester_t            winner;

    assign i_req = imem_read;
    assign d_req = dmem_read | dmem_write;

    // Arbitration and next-state logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        load         = 1'b0;
        winner       = REQ_I;

        case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    load = 1'b1;
                    if (i_req && d_req) begin
                        // Tie: the side that did not win last time goes now.
                        winner = (last_grant_q == REQ_I) ? REQ_D : REQ_I;
                    end else begin
                        winner = d_req ? REQ_D : REQ_I;
                    end
                    state_d      = (winner == REQ_D) ? ARB_GRANT_D : ARB_GRANT_I;
                    last_grant_d = winner;
                end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
                if (mem_resp) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Request-register next values, captured only on the grant transition
    always_comb begin
        req_read_d  = req_read_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;

        if (load) begin
            if (winner == REQ_I) begin
                req_read_d  = 1'b1;
                req_write_d = 1'b0;
                req_addr_d  = imem_address;
                req_wdata_d = '0;
                req_be_d    = '1;
            end else begin
                // read+write together is illegal; it is treated as a write.
                req_read_d  = dmem_read & ~dmem_write;
                req_write_d = dmem_write;
                req_addr_d  = dmem_address;
                req_wdata_d = dmem_wdata;
                req_be_d    = dmem_byte_enable;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= REQ_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_read_q  <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
        end else begin
            req_read_q  <= req_read_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
        end
    end

    // Memory port is driven purely from the latched request; strobes are
    // gated by the grant states so nothing leaks out while idle.
    always_comb begin
        mem_read        = (state_q != ARB_IDLE) & req_read_q;
        mem_write       = (state_q != ARB_IDLE) & req_write_q;
        mem_address     = req_addr_q;
        mem_wdata       = req_wdata_q;
        mem_byte_enable = req_be_q;

        // Responses are gated by rst_n so a late mem_resp during reset is dropped.
        imem_resp  = rst_n & mem_resp & (state_q == ARB_GRANT_I);
        dmem_resp  = rst_n & mem_resp & (state_q == ARB_GRANT_D);
        imem_rdata = mem_rdata;
        dmem_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    logic        model_resp;
    logic        force_resp;
    logic        model_en;
    assign mem_resp = model_resp | force_resp;

    mem_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_read        (imem_read),
        .imem_address     (imem_address),
        .imem_rdata       (imem_rdata),
        .imem_resp        (imem_resp),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_resp         (mem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        is_write;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_i[$];
    exp_t exp_d[$];
    logic grant_log[$];   // 0 = fetch, 1 = data

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem_bytes [0:65535];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Memory model: fixed latency, byte-addressed, little-endian halfwords.
    initial begin : mem_model
        int cnt;
        logic [15:0] lo;
        logic [15:0] hi;
        cnt        = 0;
        model_resp = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            model_resp = 1'b0;
            if (model_en && rst_n && (mem_read || mem_write)) begin
                if (cnt >= LAT - 1) begin
                    lo = {mem_address[15:1], 1'b0};
                    hi = {mem_address[15:1], 1'b1};
                    if (mem_write) begin
                        if (mem_byte_enable[0]) mem_bytes[lo] = mem_wdata[7:0];
                        if (mem_byte_enable[1]) mem_bytes[hi] = mem_wdata[15:8];
                    end else begin
                        mem_rdata = {mem_bytes[hi], mem_bytes[lo]};
                    end
                    model_resp = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops expected responses and checks port protocol.
    initial begin : monitor
        exp_t e;
        logic prev_resp;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write)
                check_eq("strobe_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
            if (prev_resp)
                check_eq("idle_after_resp", {30'd0, mem_read, mem_write}, 32'd0);
            prev_resp = (imem_resp === 1'b1) || (dmem_resp === 1'b1);
            if (imem_resp === 1'b1) begin
                check_eq("single_resp", {31'd0, dmem_resp}, 32'd0);
                grant_log.push_back(1'b0);
                if (exp_i.size() == 0) begin
                    check_eq("imem_resp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_i.pop_front();
                    check_eq("imem_rdata", {16'd0, imem_rdata}, {16'd0, e.rdata});
                end
            end
            if (dmem_resp === 1'b1) begin
                grant_log.push_back(1'b1);
                if (exp_d.size() == 0) begin
                    check_eq("dmem_resp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_d.pop_front();
                    if (!e.is_write)
                        check_eq("dmem_rdata", {16'd0, dmem_rdata}, {16'd0, e.rdata});
                end
            end
        end
    end

    task automatic wait_grants(input int n);
        int k;
        k = 0;
        while (grant_log.size() < n && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("grant_count", grant_log.size(), n);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        imem_read = 1'b0; imem_address = '0;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_byte_enable = '0;
        dmem_address = '0; dmem_wdata = '0;
        force_resp = 1'b0;
        model_en   = 1'b1;
        mem_bytes[16'h0040] = 8'h34; mem_bytes[16'h0041] = 8'h12;
        mem_bytes[16'h0102] = 8'h11; mem_bytes[16'h0103] = 8'h22;
        mem_bytes[16'h0200] = 8'hC3; mem_bytes[16'h0201] = 8'hA5;
        mem_bytes[16'h0104] = 8'h00; mem_bytes[16'h0105] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check_eq("rst_resps", {30'd0, imem_resp, dmem_resp}, 32'd0);
        check_eq("rst_addr", {16'd0, mem_address}, 32'd0);
        check_eq("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        check_eq("rst_be", {30'd0, mem_byte_enable}, 32'd0);
        rst_n = 1'b1;

        // Single fetch
        @(posedge clk); #1;
        grant_log.delete();
        exp_i.push_back('{1'b0, 16'h1234});
        imem_read = 1'b1; imem_address = 16'h0040;
        @(posedge clk); #1;
        check_eq("fetch_read", {30'd0, mem_read, mem_write}, 32'd2);
        check_eq("fetch_addr", {16'd0, mem_address}, 32'h0040);
        check_eq("fetch_be", {30'd0, mem_byte_enable}, 32'd3);
        wait_grants(1);
        imem_read = 1'b0;
        check_eq("fetch_winner", {31'd0, grant_log[0]}, 32'd0);

        // Store with upper-byte mask
        grant_log.delete();
        exp_d.push_back('{1'b1, 16'h0000});
        dmem_write = 1'b1; dmem_address = 16'h0102; dmem_wdata = 16'hBEEF;
        dmem_byte_enable = 2'b10;
        @(posedge clk); #1;
        check_eq("store_strobes", {30'd0, mem_read, mem_write}, 32'd1);
        check_eq("store_addr", {16'd0, mem_address}, 32'h0102);
        check_eq("store_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        check_eq("store_be", {30'd0, mem_byte_enable}, 32'd2);
        wait_grants(1);
        dmem_write = 1'b0;
        check_eq("store_hi_byte", {24'd0, mem_bytes[16'h0103]}, 32'hBE);
        check_eq("store_lo_byte", {24'd0, mem_bytes[16'h0102]}, 32'h11);

        // Continuous contention from reset: D, I, D, I
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        grant_log.delete();
        exp_i.push_back('{1'b0, 16'h1234});
        exp_i.push_back('{1'b0, 16'h1234});
        exp_d.push_back('{1'b0, 16'hA5C3});
        exp_d.push_back('{1'b0, 16'hA5C3});
        imem_read = 1'b1; imem_address = 16'h0040;
        dmem_read = 1'b1; dmem_address = 16'h0200; dmem_byte_enable = 2'b11;
        wait_grants(4);
        imem_read = 1'b0; dmem_read = 1'b0;
        if (grant_log.size() >= 4) begin
            check_eq("contend_0", {31'd0, grant_log[0]}, 32'd1);
            check_eq("contend_1", {31'd0, grant_log[1]}, 32'd0);
            check_eq("contend_2", {31'd0, grant_log[2]}, 32'd1);
            check_eq("contend_3", {31'd0, grant_log[3]}, 32'd0);
        end

        // Withdrawn data request still completes with latched address
        @(posedge clk); #1;
        grant_log.delete();
        exp_d.push_back('{1'b0, 16'hA5C3});
        dmem_read = 1'b1; dmem_address = 16'h0200;
        @(posedge clk); #1;
        check_eq("wd_addr_grant", {16'd0, mem_address}, 32'h0200);
        dmem_read = 1'b0; dmem_address = 16'h0300;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (grant_log.size() > 0) break;
            check_eq("wd_addr_held", {16'd0, mem_address}, 32'h0200);
            check_eq("wd_read_held", {31'd0, mem_read}, 32'd1);
        end
        check_eq("wd_resp", grant_log.size(), 32'd1);

        // Reset while a fetch is in flight, with stray mem_resp pulses
        model_en = 1'b0;
        grant_log.delete();
        imem_read = 1'b1; imem_address = 16'h0040;
        @(posedge clk); #1;
        check_eq("mid_granted", {31'd0, mem_read}, 32'd1);
        rst_n = 1'b0; imem_read = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check_eq("mid_addr", {16'd0, mem_address}, 32'd0);
        force_resp = 1'b1;
        @(negedge clk);
        check_eq("mid_resp_rst", {30'd0, imem_resp, dmem_resp}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_resp_idle", {30'd0, imem_resp, dmem_resp}, 32'd0);
        @(posedge clk); #1;
        force_resp = 1'b0;
        model_en = 1'b1;
        check_eq("mid_no_resp", grant_log.size(), 32'd0);
        exp_d.push_back('{1'b0, 16'hA5C3});
        exp_i.push_back('{1'b0, 16'h1234});
        imem_read = 1'b1; imem_address = 16'h0040;
        dmem_read = 1'b1; dmem_address = 16'h0200;
        wait_grants(2);
        imem_read = 1'b0; dmem_read = 1'b0;
        if (grant_log.size() >= 2) begin
            check_eq("post_rst_tie_0", {31'd0, grant_log[0]}, 32'd1);
            check_eq("post_rst_tie_1", {31'd0, grant_log[1]}, 32'd0);
        end

        // Illegal read+write: treated as a write
        @(posedge clk); #1;
        grant_log.delete();
        exp_d.push_back('{1'b1, 16'h0000});
        dmem_read = 1'b1; dmem_write = 1'b1; dmem_address = 16'h0104;
        dmem_wdata = 16'h1357; dmem_byte_enable = 2'b11;
        @(posedge clk); #1;
        check_eq("illegal_strobes", {30'd0, mem_read, mem_write}, 32'd1);
        wait_grants(1);
        dmem_read = 1'b0; dmem_write = 1'b0;
        check_eq("illegal_lo_byte", {24'd0, mem_bytes[16'h0104]}, 32'h57);
        check_eq("illegal_hi_byte", {24'd0, mem_bytes[16'h0105]}, 32'h13);

        repeat (3) @(posedge clk);
        #1;
        check_eq("exp_i_drained", exp_i.size(), 32'd0);
        check_eq("exp_d_drained", exp_d.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
